// File: rtl/nor3_truth_table_sequencer.sv
`timescale 1ns/1ps
// nor3_truth_table_sequencer
// Self-test controller for a three-input NOR gate. On start it walks
// {A,B,C} through vectors 0..7, lets D settle for SETTLE_CYCLES cycles
// after each new vector, samples D once, and records the captured value
// and a mismatch bit per vector. A pass flag summarises the whole sweep.
module nor3_truth_table_sequencer #(
    parameter int SETTLE_CYCLES = 2   // legal range 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       D,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [7:0] fail_map
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // Counter value on the last settle cycle; the sample follows it.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] vec;
    logic [7:0] settle_cnt;
    logic       settle_done;
    logic       last_vec;

    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign last_vec    = (vec == 3'd7);

    // The vector register drives the gate inputs directly, so A/B/C are
    // glitch-free registered outputs with no path from any input.
    assign {A, B, C} = vec;

    // State register with synchronous reset; reset aborts any sweep.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register sees pre-edge values of its neighbours.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start is only honoured in IDLE.
    always_comb begin
        // NOTE: default first so no path through the case leaves
        // state_nxt unassigned, which would infer a latch.
        state_nxt = state;
        case (state)
            S_IDLE:   if (start)       state_nxt = S_DRIVE;
            S_DRIVE:  if (settle_done) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = last_vec ? S_DONE : S_DRIVE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_DRIVE:  busy = 1'b1;
            S_SAMPLE: busy = 1'b1;
            S_DONE:   done = 1'b1;
            default:  ;
        endcase
    end

    // Datapath: vector stepping, settle counting, result capture and pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec        <= 3'b000;
            settle_cnt <= 8'd0;
            captured   <= 8'h00;
            fail_map   <= 8'h00;
            pass       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Results from the previous sweep stay visible until
                    // a new sweep is actually accepted.
                    if (start) begin
                        vec        <= 3'b000;
                        settle_cnt <= 8'd0;
                        captured   <= 8'h00;
                        fail_map   <= 8'h00;
                        pass       <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                end
                S_SAMPLE: begin
                    // NOR is 1 only for vector 0, so a mismatch is D
                    // differing from (vec == 0).
                    captured[vec] <= D;
                    fail_map[vec] <= D ^ (vec == 3'b000);
                    if (!last_vec) begin
                        vec        <= vec + 3'd1;
                        settle_cnt <= 8'd0;
                    end
                end
                S_DONE: begin
                    // fail_map already holds vector 7's result here.
                    pass <= ~|fail_map;
                    vec  <= 3'b000;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nor3_truth_table_sequencer.sv
`timescale 1ns/1ps
// Testbench for nor3_truth_table_sequencer. Two instances: SETTLE_CYCLES=2
// driven one sweep at a time, and SETTLE_CYCLES=1 driven with start held.
module tb_nor3_truth_table_sequencer;

    localparam int P0 = 3;   // cycles per vector, SETTLE_CYCLES=2
    localparam int P1 = 2;   // cycles per vector, SETTLE_CYCLES=1

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, d, start1, d1;
    logic       a, b, c, busy, done, pass;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [7:0] captured, fail_map, captured1, fail_map1;

    int checks   = 0;
    int failures = 0;

    nor3_truth_table_sequencer #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .D(d),
        .A(a), .B(b), .C(c), .busy(busy), .done(done), .pass(pass),
        .captured(captured), .fail_map(fail_map)
    );

    nor3_truth_table_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .D(d1),
        .A(a1), .B(b1), .C(c1), .busy(busy1), .done(done1), .pass(pass1),
        .captured(captured1), .fail_map(fail_map1)
    );

    // Advance one clock; outputs are observed 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; d = 1'b0; start1 = 1'b0; d1 = 1'b0;
        step(); step();
        rst = 1'b0;
        checks++; if ({a, b, c} !== 3'b000) begin failures++; $display("FAIL reset_abc got=%b exp=000", {a, b, c}); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_status busy=%b done=%b exp=0/0", busy, done); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b exp=0", pass); end
        checks++; if (captured !== 8'h00 || fail_map !== 8'h00) begin failures++; $display("FAIL reset_maps cap=%h fm=%h exp=00/00", captured, fail_map); end
        checks++; if (busy1 !== 1'b0 || {a1, b1, c1} !== 3'b000) begin failures++; $display("FAIL reset_dut1 busy=%b abc=%b exp=0/000", busy1, {a1, b1, c1}); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_start busy=%b exp=0", busy); end
    endtask

    // One full sweep on dut. tt is the gate's truth table: D equals tt[vec]
    // on every cycle feeding a sample edge and is random noise otherwise.
    // restart_j pulses start mid-sweep; rst_j asserts reset mid-sweep.
    task automatic run_sweep(input string name, input logic [7:0] tt,
                             input int restart_j, input int rst_j);
        int done_cnt;
        done_cnt = 0;
        start = 1'b1;
        step();                 // edge T0: start accepted
        start = 1'b0;
        for (int j = 0; j <= 25; j++) begin
            if (done === 1'b1) done_cnt++;
            if (j < 8 * P0) begin
                checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL %s_busy j=%0d busy=%b done=%b exp=1/0", name, j, busy, done); end
                checks++; if ({a, b, c} !== 3'(j / P0)) begin failures++; $display("FAIL %s_vec j=%0d got=%0d exp=%0d", name, j, {a, b, c}, j / P0); end
            end else if (j == 8 * P0) begin
                checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL %s_done j=%0d done=%b busy=%b exp=1/0", name, j, done, busy); end
                checks++; if (captured !== tt) begin failures++; $display("FAIL %s_captured got=%h exp=%h", name, captured, tt); end
                checks++; if (fail_map !== (tt ^ 8'h01)) begin failures++; $display("FAIL %s_fail_map got=%h exp=%h", name, fail_map, tt ^ 8'h01); end
            end else begin
                checks++; if (done !== 1'b0 || busy !== 1'b0 || {a, b, c} !== 3'b000) begin failures++; $display("FAIL %s_post done=%b busy=%b abc=%b exp=0/0/000", name, done, busy, {a, b, c}); end
                checks++; if (pass !== (tt == 8'h01)) begin failures++; $display("FAIL %s_pass got=%b exp=%b", name, pass, tt == 8'h01); end
                checks++; if (done_cnt != 1) begin failures++; $display("FAIL %s_done_count got=%0d exp=1", name, done_cnt); end
            end
            if (j == rst_j) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                checks++; if (busy !== 1'b0 || {a, b, c} !== 3'b000) begin failures++; $display("FAIL %s_abort busy=%b abc=%b exp=0/000", name, busy, {a, b, c}); end
                checks++; if (captured !== 8'h00 || fail_map !== 8'h00 || pass !== 1'b0) begin failures++; $display("FAIL %s_abort_maps cap=%h fm=%h pass=%b exp=00/00/0", name, captured, fail_map, pass); end
                done_cnt = 0;
                for (int k = 0; k < 30; k++) begin
                    d = 1'($urandom);
                    step();
                    if (done === 1'b1 || busy === 1'b1) done_cnt++;
                end
                checks++; if (done_cnt != 0) begin failures++; $display("FAIL %s_abort_activity got=%0d exp=0", name, done_cnt); end
                return;
            end
            start = (j == restart_j);
            d = (j < 8 * P0 && (j + 1) % P0 == 0) ? tt[j / P0] : 1'($urandom);
            step();
        end
    endtask

    // After a sweep the results must hold while D wiggles and start is low.
    task automatic test_hold(input logic [7:0] tt);
        for (int k = 0; k < 6; k++) begin
            d = 1'($urandom);
            step();
            checks++; if (captured !== tt || fail_map !== (tt ^ 8'h01) || pass !== (tt == 8'h01) || busy !== 1'b0) begin
                failures++; $display("FAIL hold k=%0d cap=%h fm=%h pass=%b busy=%b exp=%h/%h/%b/0", k, captured, fail_map, pass, busy, tt, tt ^ 8'h01, tt == 8'h01);
            end
        end
    endtask

    task automatic test_correct_nor();    run_sweep("nor",     8'h01, -1, -1); test_hold(8'h01); endtask
    task automatic test_stuck_low();      run_sweep("stuck0",  8'h00, -1, -1); endtask
    task automatic test_stuck_high();     run_sweep("stuck1",  8'hFF, -1, -1); endtask
    task automatic test_restart_ignored();
        run_sweep("restart", 8'h01, 3 * P0, -1);
        run_sweep("rerun",   8'h5A, -1, -1);
    endtask
    task automatic test_reset_mid_sweep(); run_sweep("rst_mid", 8'hFF, -1, 5 * P0); endtask

    task automatic test_random_tables();
        for (int n = 0; n < 6; n++) begin
            logic [7:0] tt;
            tt = 8'($urandom);
            if (n == 0) tt = 8'h01;
            run_sweep("random", tt, -1, -1);
        end
    endtask

    // dut1: start held high, D follows NOR of the gate inputs one cycle late.
    task automatic test_back_to_back();
        logic [2:0] last_abc;
        last_abc = 3'b000;
        start1 = 1'b1;
        d1 = 1'b1;
        step();                 // edge T0
        for (int j = 0; j < 36; j++) begin
            int m;
            m = j % (8 * P1 + 2);
            if (m < 8 * P1) begin
                checks++; if (busy1 !== 1'b1 || done1 !== 1'b0 || {a1, b1, c1} !== 3'(m / P1)) begin failures++; $display("FAIL b2b_run j=%0d busy=%b done=%b abc=%0d exp=1/0/%0d", j, busy1, done1, {a1, b1, c1}, m / P1); end
            end else if (m == 8 * P1) begin
                checks++; if (done1 !== 1'b1 || captured1 !== 8'h01 || fail_map1 !== 8'h00) begin failures++; $display("FAIL b2b_done j=%0d done=%b cap=%h fm=%h exp=1/01/00", j, done1, captured1, fail_map1); end
            end else begin
                checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || pass1 !== 1'b1) begin failures++; $display("FAIL b2b_idle j=%0d busy=%b done=%b pass=%b exp=0/0/1", j, busy1, done1, pass1); end
            end
            d1 = ~|last_abc;
            last_abc = {a1, b1, c1};
            step();
        end
        start1 = 1'b0;
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL b2b_third busy=%b exp=1", busy1); end
        for (int k = 0; k < 8 * P1 + 2; k++) begin
            d1 = ~|last_abc;
            last_abc = {a1, b1, c1};
            step();
        end
        checks++; if (busy1 !== 1'b0 || pass1 !== 1'b1) begin failures++; $display("FAIL b2b_end busy=%b pass=%b exp=0/1", busy1, pass1); end
    endtask

    initial begin
        test_reset();
        test_correct_nor();
        test_stuck_low();
        test_stuck_high();
        test_restart_ignored();
        test_reset_mid_sweep();
        test_random_tables();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nor3_truth_table_sequencer.md
Name: nor3_truth_table_sequencer

Overview:
- Self-test controller for the three-input NOR gate datapath.
- On a start request, it walks {A,B,C} through all 8 input combinations and waits a programmable settle time after each.
- It then samples D and compares it against the expected NOR value.
- Results are a per-vector capture map, a per-vector mismatch map and a single pass flag, for display on board LEDs or readback by a top-level lab wrapper.

Parameters:
- SETTLE_CYCLES, 2, clock cycles D is allowed to settle after each new vector before sampling; legal range 1..255; an 8-bit counter is sufficient.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to run a full sweep; sampled only in IDLE
- D  input  1  output of the NOR gate under test
- A  output  1  gate input A (vector bit 2)
- B  output  1  gate input B (vector bit 1)
- C  output  1  gate input C (vector bit 0)
- busy  output  1  high while a sweep is in progress (DRIVE or SAMPLE)
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  1 if the last completed sweep had zero mismatches; held until the next start
- captured  output  8  captured[i] = D sampled while {A,B,C}=i
- fail_map  output  8  fail_map[i] = 1 if captured[i] != ~(i[2]|i[1]|i[0])

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, {A,B,C}=3'b000, busy=0, done=0, pass=0, captured=0, fail_map=0, settle counter=0. Reset wins over every other event, including mid-sweep: the sweep is aborted and no done pulse is produced.
- Internal register vec[2:0] drives {A,B,C} directly (registered outputs, no combinational path from any input).
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - busy=0.
  - On start=1: vec<=0, counter<=0, captured<=0, fail_map<=0, pass<=0; next state DRIVE.
  - Otherwise stay in IDLE; outputs hold their last values.
- DRIVE:
  - busy=1; counter increments each cycle.
  - When counter == SETTLE_CYCLES-1, next state SAMPLE; otherwise stay in DRIVE.
  - Result: vec is stable for exactly SETTLE_CYCLES cycles before the sample cycle.
- SAMPLE:
  - busy=1; captured[vec]<=D; fail_map[vec]<=D ^ (vec==3'b000).
  - If vec==7, next state DONE.
  - Otherwise vec<=vec+1, counter<=0, next state DRIVE.
  - No wrap-around of vec occurs within a sweep.
- DONE:
  - busy=0, done=1 for this single cycle.
  - pass is computed from the final fail_map, including the last vector's result: pass<=~|(fail_map with bit 7 updated).
  - vec<=0 (A=B=C=0); next state IDLE.
- Latency: start accepted at edge T0. Vector i is sampled at edge T0 + (i+1)*(SETTLE_CYCLES+1). done is high in the cycle after edge T0 + 8*(SETTLE_CYCLES+1); for SETTLE_CYCLES=2 that is edge T0+24.
- start while busy or in DONE: ignored, no restart, no effect on maps.
- start held high continuously: a new sweep begins on the first IDLE cycle after DONE, so back-to-back sweeps are separated by exactly one IDLE cycle.
- D is not sampled outside SAMPLE; glitches during DRIVE have no effect.
- captured/fail_map/pass remain valid and stable from the done pulse until the next accepted start.

Test Plan:
- Correct NOR model on D, SETTLE_CYCLES=2, one start pulse -> vectors 0..7 each held 3 cycles; done pulses once, 24 cycles after the start edge; captured=8'h01, fail_map=8'h00, pass=1.
- D stuck at 0 -> captured=8'h00, fail_map=8'h01, pass=0, done timing unchanged.
- D stuck at 1 -> captured=8'hFF, fail_map=8'hFE, pass=0.
- start pulsed again at vector 3 of a running sweep -> ignored: vec continues 4..7, exactly one done pulse; a new start after done clears the maps and reruns the sweep.
- rst asserted during DRIVE of vector 5 -> next cycle: IDLE, A=B=C=0, busy=0, captured=fail_map=0, pass=0; no done pulse.
- SETTLE_CYCLES=1 with start held high -> first done 16 cycles after start; second sweep begins after one IDLE cycle; D model with a one-cycle delay still yields pass=1.
